aes_key_expand: RTL and testbench

Iterative AES key-schedule generator. Sits directly upstream of the AES core's round pipeline. It accepts a cipher key and streams the round keys in order, one 128-bit round key per valid/ready handshake: round 0 first, round NUM_ROUNDS last. It supports 128-bit keys (11 round keys) and 256-bit keys (15 round keys), with one new round key computed per cycle.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_expand.sv | 127 ++++++++++++
 tb/tb_aes_key_expand.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, rcon helpers, key-schedule FSM states and the S-box table.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  function automatic int unsigned num_rounds(input int unsigned key_width);
    return (key_width == 128) ? 10 : 14;
  endfunction

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry 0 sits in the MSBs so SBOX[n] is the substitution of byte n.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, substituted byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/256 key schedule; streams one 128-bit round key per valid/ready handshake.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 128,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [KEY_WIDTH-1:0]  i_key_in,
  output logic                  o_ready,
  output logic                  o_rk_valid,
  input  logic                  i_rk_ready,
  output logic [DATA_WIDTH-1:0] o_rk_out,
  output logic [3:0]            o_rk_index,
  output logic                  o_done
);

  if ((KEY_WIDTH != 128 && KEY_WIDTH != 256) || DATA_WIDTH != 128) begin : g_bad_params
    $error("aes_key_expand: KEY_WIDTH must be 128 or 256 and DATA_WIDTH must be 128");
  end

  localparam logic [3:0] LastIdx = 4'(num_rounds(KEY_WIDTH));

  state_e                r_state;
  logic [KEY_WIDTH-1:0]  r_win;
  logic [DATA_WIDTH-1:0] r_rk;
  logic [7:0]            r_rcon;
  logic [3:0]            r_idx;
  logic                  r_ready;
  logic                  r_valid;
  logic                  r_done;

  logic [31:0]  w_last;
  logic [127:0] w_base;
  logic [3:0]   w_next_idx;
  logic         w_use_rcon;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_new;
  logic [KEY_WIDTH-1:0]  w_win_next;
  logic [DATA_WIDTH-1:0] w_rk_next;

  // The oldest quad of the window combines with the newest word, as in FIPS-197 w[i-Nk] ^ temp.
  assign w_last     = r_win[31:0];
  assign w_base     = r_win[KEY_WIDTH-1 -: 128];
  assign w_next_idx = r_idx + 4'd1;
  assign w_use_rcon = (KEY_WIDTH == 128) || !w_next_idx[0];
  assign w_sub_in   = w_use_rcon ? {w_last[23:0], w_last[31:24]} : w_last;

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_sub_in[8*g +: 8]),
      .o_byte (w_sub_out[8*g +: 8])
    );
  end

  assign w_temp = w_sub_out ^ (w_use_rcon ? {r_rcon, 24'h0} : 32'h0);
  assign w_n0   = w_base[127:96] ^ w_temp;
  assign w_n1   = w_base[95:64]  ^ w_n0;
  assign w_n2   = w_base[63:32]  ^ w_n1;
  assign w_n3   = w_base[31:0]   ^ w_n2;
  assign w_new  = {w_n0, w_n1, w_n2, w_n3};

  if (KEY_WIDTH == 128) begin : g_k128
    assign w_win_next = w_new;
    assign w_rk_next  = w_new;
  end else begin : g_k256
    // Round 1 is simply the lower key half; the window only starts sliding from round 2.
    assign w_win_next = (r_idx == 4'd0) ? r_win : {r_win[127:0], w_new};
    assign w_rk_next  = (r_idx == 4'd0) ? r_win[127:0] : w_new;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_win   <= '0;
      r_rk    <= '0;
      r_rcon  <= RCON_INIT;
      r_idx   <= 4'd0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_win   <= i_key_in;
            r_rk    <= i_key_in[KEY_WIDTH-1 -: 128];
            r_rcon  <= RCON_INIT;
            r_idx   <= 4'd0;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
            r_state <= StEmit;
          end
        end
        StEmit: begin
          if (i_rk_ready) begin
            if (r_idx == LastIdx) begin
              r_ready <= 1'b1;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_win <= w_win_next;
              r_rk  <= w_rk_next;
              r_idx <= w_next_idx;
              if (w_use_rcon) r_rcon <= xtime(r_rcon);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_rk_valid = r_valid;
  assign o_rk_out   = r_rk;
  assign o_rk_index = r_idx;
  assign o_done     = r_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: AES-128 and AES-256 instances driven with FIPS-197 vectors.
module tb_aes_key_expand;
  import aes_pkg::*;

  localparam logic [127:0] KeyA1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KeyA3  =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KeyAlt = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KeyBad = 128'hffeeddccbbaa99887766554433221100;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         sa, rra, ra, va, da;
  logic [127:0] ka, rka;
  logic [3:0]   ia;
  logic         sb, rrb, rb, vb, db;
  logic [255:0] kb;
  logic [127:0] rkb;
  logic [3:0]   ib;

  aes_key_expand #(.KEY_WIDTH(128), .DATA_WIDTH(128)) u_dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (sa), .i_key_in (ka), .o_ready (ra),
    .o_rk_valid (va), .i_rk_ready (rra), .o_rk_out (rka), .o_rk_index (ia), .o_done (da)
  );

  aes_key_expand #(.KEY_WIDTH(256), .DATA_WIDTH(128)) u_dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (sb), .i_key_in (kb), .o_ready (rb),
    .o_rk_valid (vb), .i_rk_ready (rrb), .o_rk_out (rkb), .o_rk_index (ib), .o_done (db)
  );

  int checks = 0;
  int errors = 0;
  int nb_keys = 0;
  logic [131:0] qa[$];
  logic [131:0] qb[$];
  logic [127:0] exp_a [0:15];
  logic [127:0] cap_a [0:15];
  logic [127:0] cap_b [0:15];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Textbook word-at-a-time schedule; pushes {index, round key} for every round.
  task automatic push_exp(input bit is256, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = is256 ? 8 : 4;
    nr = is256 ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[(nk-1-i)*32 +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (is256) qb.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      else begin
        qa.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        exp_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
    end
  endtask

  initial begin : mon_a
    logic [131:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (da) check("a_done_with_valid", va, 0);
        if (va && rra) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_key idx %0d got %h want none", ia, rka);
          end else begin
            e = qa.pop_front();
            check("a_rk_index", ia, e[131:128]);
            check("a_rk_out", rka, e[127:0]);
          end
          cap_a[ia] = rka;
        end
      end
    end
  end

  initial begin : mon_b
    logic [131:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (db) check("b_done_with_valid", vb, 0);
        if (vb && rrb) begin
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_key idx %0d got %h want none", ib, rkb);
          end else begin
            e = qb.pop_front();
            check("b_rk_index", ib, e[131:128]);
            check("b_rk_out", rkb, e[127:0]);
          end
          cap_b[ib] = rkb;
          nb_keys++;
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that accepted start.
  task automatic start_run(input bit b, input logic [255:0] key);
    if (b) begin sb = 1'b1; kb = key; end
    else begin sa = 1'b1; ka = key[127:0]; end
    push_exp(b, key);
    @(posedge clk); #1;
    sa = 1'b0;
    sb = 1'b0;
  endtask

  task automatic wait_done(input bit b, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(b ? db : da) && n < 60);
  endtask

  task automatic wait_idx(input bit b, input logic [3:0] idx);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      hit = b ? (vb && ib == idx) : (va && ia == idx);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_idx%0d got timeout want index presented", idx);
    end
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b0; sa = 1'b0; sb = 1'b0; rra = 1'b1; rrb = 1'b1; ka = '0; kb = '0;
    #12;
    check("a_rst_ready", ra, 1);  check("a_rst_valid", va, 0); check("a_rst_done", da, 0);
    check("a_rst_index", ia, 0);  check("a_rst_rk", rka, 0);
    check("b_rst_ready", rb, 1);  check("b_rst_valid", vb, 0); check("b_rst_done", db, 0);
    check("b_rst_index", ib, 0);  check("b_rst_rk", rkb, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 FIPS-197 A.1, no backpressure
    start_run(0, {128'h0, KeyA1});
    wait_done(0, n);
    check("a1_done_latency", n, 11);
    check("a1_ready_in_done", ra, 1);
    check("a1_idx1", cap_a[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("a1_idx10", cap_a[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a1_queue_drained", qa.size(), 0);

    // restart in the done cycle, then stall at index 4 and try a start at index 6
    start_run(0, {128'h0, KeyAlt});
    check("restart_valid", va, 1);
    check("restart_idx0", ia, 0);
    wait_idx(0, 3);
    @(posedge clk); #1 rra = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", va, 1);
      check("stall_idx", ia, 4);
      check("stall_rk", rka, exp_a[4]);
      @(posedge clk); #1;
    end
    rra = 1'b1;
    wait_idx(0, 5);
    @(posedge clk); #1 sa = 1'b1; ka = KeyBad;
    @(posedge clk); #1 sa = 1'b0; ka = '0;
    wait_done(0, n);
    check("alt_done_seen", da, 1);
    check("alt_queue_drained", qa.size(), 0);

    // asynchronous reset in the middle of an expansion
    start_run(0, {128'h0, KeyA1});
    wait_idx(0, 4);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", va, 0); check("midrst_ready", ra, 1); check("midrst_done", da, 0);
    check("midrst_index", ia, 0); check("midrst_rk", rka, 0);
    qa.delete();
    repeat (2) begin
      @(posedge clk); #1 check("midrst_no_done", da, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_run(0, {128'h0, KeyA1});
    wait_done(0, n);
    check("post_rst_done_latency", n, 11);
    check("post_rst_queue_drained", qa.size(), 0);

    // AES-256 FIPS-197 A.3
    nb_keys = 0;
    start_run(1, KeyA3);
    wait_done(1, n);
    check("a3_done_latency", n, 15);
    check("a3_key_count", nb_keys, 15);
    check("a3_idx2", cap_b[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("a3_idx14", cap_b[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check("a3_queue_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
